// File: rtl/evm_pkg.sv
// evm_pkg: shared types and helpers for the ballot-unit button front end.
//   btn_state_t   : vote FSM states (IDLE, LOCKOUT)
//   ERR_CNT_W     : width of the optional saturating conflict counter
//   onehot_to_bin : one-hot to binary index conversion used for vote_id
package evm_pkg;

   typedef enum logic {
      IDLE    = 1'b0,
      LOCKOUT = 1'b1
   } btn_state_t;

   localparam int ERR_CNT_W = 8;

   // OR-combines the indices of all set bits. Callers guarantee a one-hot
   // input, so no priority chain is needed. Handles up to 32 channels.
   function automatic logic [31:0] onehot_to_bin(input logic [31:0] onehot);
      logic [31:0] idx;
      idx = '0;
      for (int i = 0; i < 32; i++) begin
         if (onehot[i]) idx = idx | 32'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/button_debounce_ch.sv
// button_debounce_ch: one candidate-button input stage.
// A 2-flop synchronizer feeds a saturating hold counter; qual_o is high
// once the synchronised level has been high for HOLD_CYCLES samples.
// Ports:
//   clock, reset : rising-edge clock, synchronous active-high reset
//   button_i     : raw asynchronous button level
//   btn_s_o      : synchronised button level
//   qual_o       : press qualified (counter saturated at HOLD_CYCLES)
module button_debounce_ch #(
   parameter int HOLD_CYCLES = 10
) (
   input  logic clock,
   input  logic reset,
   input  logic button_i,
   output logic btn_s_o,
   output logic qual_o
);

   localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
   localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES);

   logic             sync1_q;
   logic             sync2_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = '0;
      if (sync2_q) begin
         // Saturate instead of wrapping so a long hold stays qualified.
         cnt_d = (cnt_q == HOLD_MAX) ? cnt_q : cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= button_i;
         sync2_q <= sync1_q;
         cnt_q   <= cnt_d;
      end
   end

   assign btn_s_o = sync2_q;
   assign qual_o  = (cnt_q == HOLD_MAX);

endmodule

// File: rtl/multi_button_control.sv
// multi_button_control: debounces CHANNELS candidate buttons and issues one
// registered one-hot vote pulse per qualified single press, or a conflict
// pulse when another button is down at qualification time. After any
// qualified press the FSM locks out until every button is released.
// Optional feature macro: BTN_ERR_CNT_EN adds the saturating err_count port.
// Ports:
//   clock, reset : rising-edge clock, synchronous active-high reset
//   button       : raw button levels, active-high
//   enable       : voting window open (clock-domain signal)
//   valid_vote   : one-hot single-cycle vote pulse
//   vote_id      : binary index of the voted channel, valid with vote_strobe
//   vote_strobe  : OR of valid_vote
//   conflict     : single-cycle pulse for a rejected simultaneous press
//   busy         : high while the FSM is in LOCKOUT (exposes FSM state)
//   err_count    : saturating conflict count (BTN_ERR_CNT_EN only)
module multi_button_control
   import evm_pkg::*;
#(
   parameter int CHANNELS    = 4,
   parameter int HOLD_CYCLES = 10
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [CHANNELS-1:0]         button,
   input  logic                        enable,
   output logic [CHANNELS-1:0]         valid_vote,
   output logic [$clog2(CHANNELS)-1:0] vote_id,
   output logic                        vote_strobe,
   output logic                        conflict,
   output logic                        busy
`ifdef BTN_ERR_CNT_EN
   ,
   output logic [ERR_CNT_W-1:0]        err_count
`endif
);

   localparam int ID_W = $clog2(CHANNELS);

   logic [CHANNELS-1:0] btn_s;
   logic [CHANNELS-1:0] qual;

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      button_debounce_ch #(
         .HOLD_CYCLES (HOLD_CYCLES)
      ) u_ch (
         .clock    (clock),
         .reset    (reset),
         .button_i (button[g]),
         .btn_s_o  (btn_s[g]),
         .qual_o   (qual[g])
      );
   end

   btn_state_t          state_q, state_d;
   logic [CHANNELS-1:0] valid_q, valid_d;
   logic [ID_W-1:0]     id_q, id_d;
   logic                strobe_q, strobe_d;
   logic                conflict_q, conflict_d;

   logic any_qual;
   logic multi_qual;
   logic clash;

   // A clash is two or more qualified channels, or one qualified channel
   // while some other synchronised button is down. With a single qual bit,
   // masking by ~qual leaves exactly the "other" buttons.
   always_comb begin
      any_qual   = |qual;
      multi_qual = (qual & (qual - CHANNELS'(1))) != '0;
      clash      = any_qual && (multi_qual || ((btn_s & ~qual) != '0));
   end

   always_comb begin
      state_d    = state_q;
      valid_d    = '0;
      id_d       = '0;
      strobe_d   = 1'b0;
      conflict_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (any_qual) begin
               // Every qualified press is consumed; enable low consumes it silently.
               state_d = LOCKOUT;
               if (enable) begin
                  if (clash) begin
                     conflict_d = 1'b1;
                  end else begin
                     valid_d  = qual;
                     id_d     = ID_W'(onehot_to_bin(32'(qual)));
                     strobe_d = 1'b1;
                  end
               end
            end
         end
         LOCKOUT: begin
            if (btn_s == '0) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         valid_q    <= '0;
         id_q       <= '0;
         strobe_q   <= 1'b0;
         conflict_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         valid_q    <= valid_d;
         id_q       <= id_d;
         strobe_q   <= strobe_d;
         conflict_q <= conflict_d;
      end
   end

   assign valid_vote  = valid_q;
   assign vote_id     = id_q;
   assign vote_strobe = strobe_q;
   assign conflict    = conflict_q;
   assign busy        = (state_q == LOCKOUT);

`ifdef BTN_ERR_CNT_EN
   logic [ERR_CNT_W-1:0] err_q;

   // Counts on the same edge that registers the conflict pulse.
   always_ff @(posedge clock) begin
      if (reset) begin
         err_q <= '0;
      end else if (conflict_d && (err_q != '1)) begin
         err_q <= err_q + ERR_CNT_W'(1);
      end
   end

   assign err_count = err_q;
`endif

endmodule

// File: tb/tb_multi_button_control.sv
// tb_multi_button_control: table-driven press scenarios, hand-written
// multi-cycle sequences and randomized stimulus, all checked every cycle
// against a history-based reference model.
module tb_multi_button_control;

   localparam int CH    = 4;
   localparam int HOLD  = 10;
   localparam int DEPTH = 16;

   // ---------------- clock / reset ----------------
   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic [CH-1:0] button = '0;
   logic          enable = 1'b1;
   logic [CH-1:0] valid_vote;
   logic [1:0]    vote_id;
   logic          vote_strobe;
   logic          conflict;
   logic          busy;
`ifdef BTN_ERR_CNT_EN
   logic [7:0]    err_count;
`endif

   always #5 clock = ~clock;

   multi_button_control #(.CHANNELS(CH), .HOLD_CYCLES(HOLD)) dut (
      .clock       (clock),
      .reset       (reset),
      .button      (button),
      .enable      (enable),
      .valid_vote  (valid_vote),
      .vote_id     (vote_id),
      .vote_strobe (vote_strobe),
      .conflict    (conflict),
      .busy        (busy)
`ifdef BTN_ERR_CNT_EN
      ,
      .err_count   (err_count)
`endif
   );

   // ---------------- scoreboard counters ----------------
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
   // hist[0] is the raw button value captured at the previous edge, hist[1]
   // the one before. A press is qualified when the synchronised history is
   // a run of at least HOLD highs.
   logic [CH-1:0] hist [DEPTH];
   logic          m_lock = 1'b0;
   logic [CH-1:0] exp_valid = '0;
   int            exp_id = 0;
   logic          exp_strobe = 1'b0;
   logic          exp_conf = 1'b0;
   int            exp_err = 0;

   task automatic model_edge(input logic [CH-1:0] b, input logic en, input logic rst);
      logic [CH-1:0] bs;
      logic [CH-1:0] ql;
      logic          clash;
      int            run;
      exp_valid  = '0;
      exp_strobe = 1'b0;
      exp_conf   = 1'b0;
      exp_id     = 0;
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) hist[i] = '0;
         m_lock  = 1'b0;
         exp_err = 0;
      end else begin
         bs = hist[1];
         for (int c = 0; c < CH; c++) begin
            run = 0;
            for (int d = 2; d < DEPTH; d++) begin
               if (!hist[d][c]) break;
               run++;
            end
            ql[c] = (run >= HOLD);
         end
         if (!m_lock) begin
            if (ql != '0) begin
               m_lock = 1'b1;
               if (en) begin
                  clash = ($countones(ql) > 1);
                  for (int i = 0; i < CH; i++)
                     for (int j = 0; j < CH; j++)
                        if (ql[i] && bs[j] && (i != j)) clash = 1'b1;
                  if (clash) begin
                     exp_conf = 1'b1;
                     if (exp_err < 255) exp_err++;
                  end else begin
                     exp_valid  = ql;
                     exp_strobe = 1'b1;
                     for (int i = 0; i < CH; i++) if (ql[i]) exp_id = i;
                  end
               end
            end
         end else if (bs == '0) begin
            m_lock = 1'b0;
         end
      end
      for (int i = DEPTH - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = rst ? '0 : b;
   endtask

   // ---------------- observation for scenario checks ----------------
   int obs_votes, obs_conf, obs_id, obs_first_id, step_idx, vote_step, rel_from, busy_clear_step;

   task automatic clear_obs();
      obs_votes = 0; obs_conf = 0; obs_id = -1; obs_first_id = -1;
      step_idx = 0; vote_step = -1; rel_from = 1 << 30; busy_clear_step = -1;
   endtask

   // ---------------- driver ----------------
   task automatic step(input logic [CH-1:0] b, input logic en, input logic rst);
      button = b;
      enable = en;
      reset  = rst;
      model_edge(b, en, rst);
      @(negedge clock);
      step_idx++;
      check("valid_vote", 32'(valid_vote), 32'(exp_valid));
      check("vote_strobe", 32'(vote_strobe), 32'(exp_strobe));
      check("conflict", 32'(conflict), 32'(exp_conf));
      check("busy", 32'(busy), 32'(m_lock));
      if (exp_strobe) check("vote_id", 32'(vote_id), 32'(exp_id));
`ifdef BTN_ERR_CNT_EN
      check("err_count", 32'(err_count), 32'(exp_err));
`endif
      if (vote_strobe) begin
         if (obs_votes == 0) begin
            obs_first_id = int'(vote_id);
            vote_step    = step_idx;
         end
         obs_id = int'(vote_id);
         obs_votes++;
      end
      if (conflict) obs_conf++;
      if (!busy && busy_clear_step < 0 && step_idx >= rel_from) busy_clear_step = step_idx;
   endtask

   task automatic hold(input logic [CH-1:0] b, input logic en, input int n);
      for (int i = 0; i < n; i++) step(b, en, 1'b0);
   endtask

   // ---------------- press table ----------------
   typedef struct {
      logic [CH-1:0] btn;
      logic          en;
      int            cycles;
      int            votes;
      int            confs;
      int            id;
   } press_t;

   press_t tbl [8];

   initial begin
      tbl[0] = '{4'b0100, 1'b1, 12, 1, 0, 2};   // plain ch2 vote
      tbl[1] = '{4'b0010, 1'b1,  9, 0, 0, -1};  // one sample short
      tbl[2] = '{4'b1001, 1'b1, 15, 0, 1, -1};  // simultaneous press
      tbl[3] = '{4'b0010, 1'b1, 10, 1, 0, 1};   // minimum accepted press
      tbl[4] = '{4'b1000, 1'b0, 20, 0, 0, -1};  // window closed
      tbl[5] = '{4'b0001, 1'b1, 40, 1, 0, 0};   // long hold, single vote
      tbl[6] = '{4'b0110, 1'b1,  9, 0, 0, -1};  // short simultaneous press
      tbl[7] = '{4'b1000, 1'b1, 11, 1, 0, 3};   // highest channel

      clear_obs();
      for (int i = 0; i < DEPTH; i++) hist[i] = '0;

      // reset state
      hold(4'b0000, 1'b1, 0);
      step(4'b0000, 1'b1, 1'b1);
      step(4'b0000, 1'b1, 1'b1);
      check("reset_valid_vote", 32'(valid_vote), 32'd0);
      check("reset_vote_id", 32'(vote_id), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);

      // table-driven presses
      for (int t = 0; t < 8; t++) begin
         clear_obs();
         hold(tbl[t].btn, tbl[t].en, tbl[t].cycles);
         hold(4'b0000, 1'b1, 8);
         check($sformatf("tbl%0d_votes", t), 32'(obs_votes), 32'(tbl[t].votes));
         check($sformatf("tbl%0d_conflicts", t), 32'(obs_conf), 32'(tbl[t].confs));
         if (tbl[t].votes > 0) check($sformatf("tbl%0d_id", t), 32'(obs_id), 32'(tbl[t].id));
         check($sformatf("tbl%0d_idle", t), 32'(busy), 32'd0);
      end

      // latency and release latency
      clear_obs();
      hold(4'b0100, 1'b1, 12);
      rel_from = step_idx + 1;
      hold(4'b0000, 1'b1, 6);
      check("latency_step", 32'(vote_step), 32'd13);
      check("release_busy_clear", 32'(busy_clear_step), 32'(rel_from + 2));

      // lockout: second press during LOCKOUT ignored, then accepted alone
      clear_obs();
      hold(4'b0010, 1'b1, 20);
      hold(4'b0110, 1'b1, 20);
      hold(4'b0000, 1'b1, 4);
      check("lockout_first_id", 32'(obs_first_id), 32'd1);
      check("lockout_votes_a", 32'(obs_votes), 32'd1);
      hold(4'b0100, 1'b1, 11);
      hold(4'b0000, 1'b1, 6);
      check("lockout_votes_b", 32'(obs_votes), 32'd2);
      check("lockout_second_id", 32'(obs_id), 32'd2);

      // enable raised after qualification: no vote, still locked
      clear_obs();
      hold(4'b1000, 1'b0, 15);
      hold(4'b1000, 1'b1, 10);
      check("late_enable_busy", 32'(busy), 32'd1);
      hold(4'b0000, 1'b1, 6);
      check("late_enable_votes", 32'(obs_votes), 32'd0);
      check("late_enable_conf", 32'(obs_conf), 32'd0);

      // reset during LOCKOUT with ch0 held
      clear_obs();
      hold(4'b0001, 1'b1, 15);
      check("pre_reset_busy", 32'(busy), 32'd1);
      step(4'b0001, 1'b1, 1'b1);
      check("post_reset_busy", 32'(busy), 32'd0);
      check("post_reset_strobe", 32'(vote_strobe), 32'd0);
      clear_obs();
      hold(4'b0001, 1'b1, 20);
      hold(4'b0000, 1'b1, 6);
      check("post_reset_vote_step", 32'(vote_step), 32'd13);
      check("post_reset_id", 32'(obs_id), 32'd0);

      // randomized segments
      for (int s = 0; s < 60; s++) begin
         logic [CH-1:0] m;
         int            r;
         int            dur;
         logic          en;
         logic          rs;
         r   = $urandom_range(0, 9);
         if (r < 6)      m = CH'(1) << $urandom_range(0, CH - 1);
         else if (r < 9) m = CH'($urandom_range(1, (1 << CH) - 1));
         else            m = '0;
         dur = $urandom_range(1, 25);
         en  = ($urandom_range(0, 7) != 0);
         rs  = ($urandom_range(0, 19) == 0);
         for (int d = 0; d < dur; d++) begin
            if ($urandom_range(0, 7) == 0) m[$urandom_range(0, CH - 1)] ^= 1'b1;
            step(m, en, rs && (d == 0));
         end
         hold(4'b0000, 1'b1, $urandom_range(0, 5));
      end
      hold(4'b0000, 1'b1, 6);

`ifdef BTN_ERR_CNT_EN
      // saturation of the conflict counter
      step(4'b0000, 1'b1, 1'b1);
      for (int k = 0; k < 300; k++) begin
         hold(4'b1001, 1'b1, 12);
         hold(4'b0000, 1'b1, 4);
      end
      check("err_count_saturated", 32'(err_count), 32'd255);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
